// File: rtl/cg_auto_ctrl_if.sv
// Bundle between a block's activity/config sources and its automatic clock-gating
// controller; the slave side is the controller.
interface cg_auto_ctrl_if #(
    parameter int IDLE_CNT_W = 8,
    parameter int GATE_CNT_W = 16
);
    logic                  cfg_cg_enable;
    logic [IDLE_CNT_W-1:0] cfg_idle_thresh;
    logic                  busy;
    logic                  wake_req;
    logic                  icg_en;
    logic                  gated;
    logic                  wake_ack;
    logic [GATE_CNT_W-1:0] gate_cnt;

    modport master (
        output cfg_cg_enable, cfg_idle_thresh, busy, wake_req,
        input  icg_en, gated, wake_ack, gate_cnt
    );

    modport slave (
        input  cfg_cg_enable, cfg_idle_thresh, busy, wake_req,
        output icg_en, gated, wake_ack, gate_cnt
    );
endinterface

// File: rtl/cg_auto_ctrl.sv
// Automatic clock-gating controller on the free-running clock: drops the ICG enable
// after a programmable idle run, re-enables on activity/wake and acks after settling.
module cg_auto_ctrl #(
    parameter int IDLE_CNT_W = 8,
    parameter int WAKE_DLY   = 2,
    parameter int GATE_CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    cg_auto_ctrl_if.slave  bus
);
    localparam int WCW = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;
    localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_DLY - 1);

    typedef enum logic [1:0] {RUN = 2'd0, GATED = 2'd1, WAKE = 2'd2} state_t;

    state_t                state;
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic [WCW-1:0]        wake_cnt;
    logic                  idle;
    logic                  hit;
    logic                  wake_cond;

    assign idle = bus.cfg_cg_enable & ~bus.busy & ~bus.wake_req &
                  (bus.cfg_idle_thresh != '0);
    assign hit = idle && (idle_cnt == (bus.cfg_idle_thresh - IDLE_CNT_W'(1)));
    assign wake_cond = bus.busy | bus.wake_req | ~bus.cfg_cg_enable;

    // Async reset forces icg_en high so the downstream domain clocks through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            bus.icg_en   <= 1'b1;
            bus.gated    <= 1'b0;
            bus.wake_ack <= 1'b0;
            bus.gate_cnt <= '0;
            idle_cnt     <= '0;
            wake_cnt     <= '0;
        end else begin
            bus.wake_ack <= (state == RUN) & bus.wake_req;
            case (state)
                RUN: begin
                    if (hit) begin
                        state      <= GATED;
                        bus.icg_en <= 1'b0;
                        bus.gated  <= 1'b1;
                        idle_cnt   <= '0;
                        if (bus.gate_cnt != '1)
                            bus.gate_cnt <= bus.gate_cnt + GATE_CNT_W'(1);
                    end else if (idle) begin
                        if (idle_cnt != '1) idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                GATED: begin
                    if (wake_cond) begin
                        state      <= WAKE;
                        bus.icg_en <= 1'b1;
                        bus.gated  <= 1'b0;
                        wake_cnt   <= '0;
                    end
                end
                WAKE: begin
                    // Settle window: no return to GATED until back in RUN.
                    if (wake_cnt == WAKE_LAST) begin
                        state    <= RUN;
                        wake_cnt <= '0;
                    end else begin
                        wake_cnt <= wake_cnt + WCW'(1);
                    end
                end
                default: begin
                    state      <= RUN;
                    bus.icg_en <= 1'b1;
                    bus.gated  <= 1'b0;
                end
            endcase
        end
    end
endmodule
